alu_seq: RTL and testbench

// Registered, handshaked successor to the combinational ALU. Operand width is
// a parameter. The result is widened to 2N so multiply and divide are lossless.
// Add, sub, multiply and the logic ops complete in one cycle. Divide is an

---
 rtl/alu_seq.sv | 112 +++++++++++
 tb/tb_alu_seq.sv | 123 ++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: registered valid/ready ALU with 2N-bit result and an N-cycle restoring divider
module alu_seq #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  input  logic [2:0]     sel,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] q,
  output logic           carry,
  output logic           zero,
  output logic           dz
);
  localparam int CW = $clog2(N + 1);
  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;
  state_t state, state_n;
  logic [N-1:0] rem, quo, dvd, dvs, rem_n, quo_n;
  logic [CW-1:0] cnt;
  logic [N:0] trial, sum;
  logic [2*N-1:0] res;
  logic res_c, acc, is_div, last;
  assign acc = in_valid && in_ready;
  assign is_div = sel == 3'b011;
  assign last = cnt == CW'(1);
  assign sum = {1'b0, a} + {1'b0, b};
  assign trial = {rem, dvd[N-1]};
  assign rem_n = trial >= {1'b0, dvs} ? N'(trial - {1'b0, dvs}) : trial[N-1:0];
  assign quo_n = {quo[N-2:0], trial >= {1'b0, dvs}};
  always_comb begin
    res = '0;
    res_c = 1'b0;
    case (sel)
      3'b000: begin
        res = {{(N-1){1'b0}}, sum};
        res_c = sum[N];
      end
      3'b001: begin
        res = {{N{1'b0}}, a - b};
        res_c = a < b;
      end
      3'b010: res = {{N{1'b0}}, a} * {{N{1'b0}}, b};
      3'b100: res = {{N{1'b0}}, a & b};
      3'b101: res = {{N{1'b0}}, a | b};
      3'b110: res = {{N{1'b0}}, a ^ b};
      3'b111: res = {{N{1'b0}}, ~(a | b)};
      default: res = '0;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = !acc ? IDLE : (is_div && b != '0) ? DIV : DONE;
      DIV: state_n = last ? DONE : DIV;
      DONE: state_n = out_ready ? IDLE : DONE;
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    in_ready = state == IDLE;
    out_valid = state == DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
      carry <= 1'b0;
      zero <= 1'b0;
      dz <= 1'b0;
      rem <= '0;
      quo <= '0;
      dvd <= '0;
      dvs <= '0;
      cnt <= '0;
    end else if (acc) begin
      if (is_div && b == '0) begin
        q <= {a, {N{1'b1}}};
        carry <= 1'b0;
        zero <= 1'b0;
        dz <= 1'b1;
      end else if (is_div) begin
        rem <= '0;
        quo <= '0;
        dvd <= a;
        dvs <= b;
        cnt <= CW'(N);
      end else begin
        q <= res;
        carry <= res_c;
        zero <= res == '0;
        dz <= 1'b0;
      end
    end else if (state == DIV) begin
      rem <= rem_n;
      quo <= quo_n;
      dvd <= {dvd[N-2:0], 1'b0};
      cnt <= cnt - 1'b1;
      if (last) begin
        q <= {rem_n, quo_n};
        carry <= 1'b0;
        zero <= {rem_n, quo_n} == '0;
        dz <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vector bench for alu_seq with N=8
module tb_alu_seq;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic [2:0] sel = '0;
  logic [15:0] q;
  logic carry, zero, dz;
  int n_vec = 0, n_err = 0;
  typedef struct {
    logic [2:0] sel;
    logic [7:0] a, b;
    logic [15:0] q;
    logic c, z, dz;
  } vec_t;
  vec_t v[18];
  always #5 clk = ~clk;
  alu_seq #(.N(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
    .q(q), .carry(carry), .zero(zero), .dz(dz)
  );
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask
  task automatic do_op(input logic [2:0] s, input logic [7:0] x, input logic [7:0] y, output int lat);
    in_valid = 1'b1;
    sel = s;
    a = x;
    b = y;
    @(posedge clk);
    #1 in_valid = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
    sel = 3'($urandom);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 40);
  endtask
  task automatic pop();
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk("pop_in_ready", 32'(in_ready), 32'd1);
    chk("pop_out_valid", 32'(out_valid), 32'd0);
  endtask
  initial begin
    int lat;
    v[0]  = '{3'd0, 8'd200, 8'd100, 16'h012C, 1'b1, 1'b0, 1'b0};
    v[1]  = '{3'd1, 8'd5,   8'd7,   16'h00FE, 1'b1, 1'b0, 1'b0};
    v[2]  = '{3'd1, 8'd9,   8'd9,   16'h0000, 1'b0, 1'b1, 1'b0};
    v[3]  = '{3'd2, 8'd255, 8'd255, 16'hFE01, 1'b0, 1'b0, 1'b0};
    v[4]  = '{3'd7, 8'hF0,  8'h0F,  16'h0000, 1'b0, 1'b1, 1'b0};
    v[5]  = '{3'd3, 8'd200, 8'd7,   16'h041C, 1'b0, 1'b0, 1'b0};
    v[6]  = '{3'd0, 8'd0,   8'd0,   16'h0000, 1'b0, 1'b1, 1'b0};
    v[7]  = '{3'd0, 8'd255, 8'd1,   16'h0100, 1'b1, 1'b0, 1'b0};
    v[8]  = '{3'd4, 8'hF0,  8'h3C,  16'h0030, 1'b0, 1'b0, 1'b0};
    v[9]  = '{3'd5, 8'hF0,  8'h0F,  16'h00FF, 1'b0, 1'b0, 1'b0};
    v[10] = '{3'd6, 8'hAA,  8'hFF,  16'h0055, 1'b0, 1'b0, 1'b0};
    v[11] = '{3'd7, 8'h00,  8'h00,  16'h00FF, 1'b0, 1'b0, 1'b0};
    v[12] = '{3'd3, 8'd255, 8'd1,   16'h00FF, 1'b0, 1'b0, 1'b0};
    v[13] = '{3'd3, 8'd7,   8'd200, 16'h0700, 1'b0, 1'b0, 1'b0};
    v[14] = '{3'd3, 8'd0,   8'd5,   16'h0000, 1'b0, 1'b1, 1'b0};
    v[15] = '{3'd3, 8'd13,  8'd0,   16'h0DFF, 1'b0, 1'b0, 1'b1};
    v[16] = '{3'd2, 8'h10,  8'h10,  16'h0100, 1'b0, 1'b0, 1'b0};
    v[17] = '{3'd1, 8'd0,   8'd1,   16'h00FF, 1'b1, 1'b0, 1'b0};
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_q", 32'(q), 32'd0);
    chk("rst_flags", 32'({carry, zero, dz}), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 18; i++) begin
      do_op(v[i].sel, v[i].a, v[i].b, lat);
      chk($sformatf("v%0d_lat", i), 32'(lat), (v[i].sel == 3'd3 && v[i].b != 8'd0) ? 32'd9 : 32'd1);
      chk($sformatf("v%0d_q", i), 32'(q), 32'(v[i].q));
      chk($sformatf("v%0d_czd", i), 32'({carry, zero, dz}), 32'({v[i].c, v[i].z, v[i].dz}));
      chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'd0);
      pop();
    end
    do_op(3'd3, 8'd13, 8'd0, lat);
    chk("dz_lat", 32'(lat), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_q", 32'(q), 32'h0DFF);
      chk("stall_dz_ov_ir", 32'({dz, out_valid, in_ready}), 32'b110);
    end
    pop();
    in_valid = 1'b1;
    sel = 3'd3;
    a = 8'd255;
    b = 8'd1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("abort_ov", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_q", 32'(q), 32'd0);
    chk("abort_flags", 32'({carry, zero, dz}), 32'd0);
    chk("abort_ov_ir", 32'({out_valid, in_ready}), 32'b01);
    repeat (12) begin
      @(negedge clk);
      chk("abort_no_result", 32'(out_valid), 32'd0);
    end
    do_op(3'd0, 8'd1, 8'd1, lat);
    chk("post_lat", 32'(lat), 32'd1);
    chk("post_q", 32'(q), 32'h0002);
    pop();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
